sevenseg_scan_ctrl: RTL and testbench
=====================================

// Module: sevenseg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an NDIGITS common-anode 7-segment display.
//  Sequences one shared BCD->segment decoder across all digits:
//    - selects one digit's nibble per time slot; drives that digit's anode enable;
//    - inserts dead time between slots to suppress ghosting.
//  New display values are double-buffered and applied only at frame boundaries (no tearing).
//  Sits between the numeric datapath (counters, ALU results) and the segment decoder/pins.
// PARAMETERS
//  NDIGITS      4     number of digits scanned (>=2)
//  ON_CYCLES    1000  clk cycles a digit is driven per slot (>=1)
//  DEAD_CYCLES  16    clk cycles all anodes off before each slot (>=1)
// PORTS
//  clk         in   1            system clock, all logic on rising edge
//  reset       in   1            synchronous, active-high
//  enable      in   1            1 = scanning runs; 0 = display dark, scan held at digit 0
//  load        in   1            1-cycle strobe: capture load_data into pending buffer
//  load_data   in   4*NDIGITS    BCD digits; [3:0] = digit 0 (least significant)
//  blank_lz    in   1            1 = suppress leading-zero digits
//  digit_data  out  4            nibble for the shared decoder (registered)
//  anode       out  NDIGITS      one-hot active-high digit enable (registered)
//  digit_idx   out  clog2(NDIGITS)  index of slot in progress (registered)
//  frame_tick  out  1            1-cycle pulse at start of each frame (registered)
// BEHAVIOUR
//  Reset:
//    - state=BLANK, digit_idx=0, slot counter=0.
//    - anode=0, digit_data=0, frame_tick=0.
//    - shadow=0, pending=0, pend_valid=0.
//  FSM, two states:
//    BLANK: anode=0 for DEAD_CYCLES cycles -> DRIVE.
//    DRIVE: ON_CYCLES cycles:
//      - anode=onehot(digit_idx), digit_data=shadow[digit_idx].
//      - then -> BLANK; digit_idx increments, wrapping NDIGITS-1 -> 0.
//  Frame:
//    - Length NDIGITS*(DEAD_CYCLES+ON_CYCLES) cycles.
//    - frame_tick=1 for exactly the first BLANK cycle of digit 0, including the first one after enable rises.
//  Buffering:
//    - load=1 writes pending<=load_data, pend_valid<=1.
//    - A later load before transfer overwrites pending (last value wins).
//    - Transfer happens on the BLANK->DRIVE transition of digit 0 when pend_valid=1:
//      shadow<=pending, pend_valid<=0.
//      The first DRIVE cycle of that frame already shows the new shadow.
//    - load on the same cycle as a transfer: the transfer uses the old pending, the new value lands
//      in pending, and pend_valid stays 1.
//  Leading-zero blanking (blank_lz=1):
//    - Digit i>=1 is blanked when shadow digits i..NDIGITS-1 are all 0.
//    - A blanked digit keeps its slot timing with anode=0; digit_data is still driven.
//    - Digit 0 is never blanked.
//    - blank_lz is sampled every cycle.
//  Non-BCD nibbles (>9) are passed through unchanged; the decoder handles them.
//  enable=0:
//    - Next edge: state=BLANK, digit_idx=0, counter=0, anode=0, frame_tick=0.
//    - Buffer loads still accepted.
//    - Deassertion mid-slot aborts the slot.
//  Reset mid-operation: all state returns to reset values at that edge; pending loads are discarded.
//  Arithmetic:
//    - Slot counter width clog2(max(ON_CYCLES,DEAD_CYCLES)).
//    - Counter compares against CYCLES-1 and clears on every state change.
// TESTING (NDIGITS=4, ON_CYCLES=3, DEAD_CYCLES=1 unless noted)
//  1. Reset, then enable=1.
//     - During reset: anode=0000, digit_data=0, frame_tick=0.
//     - After release: frame_tick pulse; 1 BLANK cycle; anode=0001 for 3 cycles; anode=0000 1 cycle; anode=0010.
//  2. load 0x1234, then run 2 frames (frame = 16 cycles, frame_tick every 16 cycles).
//     - Next frame shows digit_data 4,3,2,1 with anode 0001,0010,0100,1000.
//  3. Leading-zero blanking.
//     - blank_lz=1, load 0x0045: slots 2 and 3 have anode=0000; digits 0 and 1 show 5,4.
//     - Then load 0x0000: only digit 0 lit, showing 0.
//  4. Double buffering.
//     - load 0x1111 during digit 1 of a frame, then 0x2222 during digit 2.
//     - Current frame is unchanged; the next frame shows 2,2,2,2.
//     - load coinciding with a transfer edge is held for the following frame.
//  5. Enable and reset mid-slot.
//     - enable=0 during the 2nd DRIVE cycle of digit 2: anode=0000, digit_idx=0 next edge.
//       Re-enable: frame_tick, then digit 0 after 1 cycle.
//     - reset during DRIVE: shadow cleared and anode=0000 at that edge.
//  6. ON_CYCLES=1000, DEAD_CYCLES=16: digit period 1016 cycles, frame 4064 cycles, no anode overlap ever.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display: one shared decoder,
// dead time between digit slots, frame-synchronous double-buffered display value.
module sevenseg_scan_ctrl #(
  parameter int unsigned NDIGITS     = 4,
  parameter int unsigned ON_CYCLES   = 1000,
  parameter int unsigned DEAD_CYCLES = 16,
  localparam int unsigned IdxW       = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 load_i,
  input  logic [4*NDIGITS-1:0] load_data_i,
  input  logic                 blank_lz_i,
  output logic [3:0]           digit_data_o,
  output logic [NDIGITS-1:0]   anode_o,
  output logic [IdxW-1:0]      digit_idx_o,
  output logic                 frame_tick_o
);

  localparam int unsigned CntMax = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] OnLast   = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NDIGITS - 1);

  typedef enum logic {StBlank, StDrive} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 run_q, run_d;
  logic [4*NDIGITS-1:0] shadow_q, shadow_d;
  logic [4*NDIGITS-1:0] pend_q, pend_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [3:0]           digit_data_q, digit_data_d;
  logic [NDIGITS-1:0]   anode_q, anode_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [NDIGITS-1:0]   lz_blank;
  logic                 upper_zero;

  // run_q low means the scan is parked; the first enabled edge starts a fresh frame with a tick.
  always_comb begin : next_state
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    run_d        = run_q;
    frame_tick_d = 1'b0;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (!enable_i) begin
      state_d = StBlank;
      cnt_d   = '0;
      idx_d   = '0;
      run_d   = 1'b0;
    end else if (!run_q) begin
      state_d      = StBlank;
      cnt_d        = '0;
      idx_d        = '0;
      run_d        = 1'b1;
      frame_tick_d = 1'b1;
    end else begin
      unique case (state_q)
        StBlank: begin
          if (cnt_q == DeadLast) begin
            state_d = StDrive;
            cnt_d   = '0;
            if ((idx_q == '0) && pend_valid_q) begin
              shadow_d     = pend_q;
              pend_valid_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDrive: begin
          if (cnt_q == OnLast) begin
            state_d      = StBlank;
            cnt_d        = '0;
            idx_d        = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
            frame_tick_d = (idx_q == IdxLast);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
    // A load on the transfer edge lands after the transfer has consumed the old value.
    if (load_i) begin
      pend_d       = load_data_i;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin : lz_calc
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = int'(NDIGITS) - 1; i >= 1; i--) begin
      upper_zero  = upper_zero & (shadow_d[4*i +: 4] == 4'h0);
      lz_blank[i] = upper_zero;
    end
  end

  // Outputs are computed from next state so the registered pins line up with state_q.
  always_comb begin : out_calc
    digit_data_d = shadow_d[{idx_d, 2'b00} +: 4];
    anode_d      = '0;
    if (state_d == StDrive) begin
      anode_d = NDIGITS'(1) << idx_d;
      if (blank_lz_i) begin
        anode_d = anode_d & ~lz_blank;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StBlank;
      cnt_q        <= '0;
      idx_q        <= '0;
      run_q        <= 1'b0;
      shadow_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      digit_data_q <= 4'h0;
      anode_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      run_q        <= run_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      digit_data_q <= digit_data_d;
      anode_q      <= anode_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign digit_data_o = digit_data_q;
  assign anode_o      = anode_q;
  assign digit_idx_o  = idx_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboarded bench for sevenseg_scan_ctrl: small-timing instance for function, plus a
// default-timing instance for slot/frame period and anode exclusivity.
module tb_sevenseg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, load, blank_lz, b_en;
  logic [15:0] load_data;
  logic [3:0]  digit_data, anode, b_data, b_anode;
  logic [1:0]  digit_idx, b_idx;
  logic        frame_tick, b_tick;

  sevenseg_scan_ctrl #(.NDIGITS(4), .ON_CYCLES(3), .DEAD_CYCLES(1)) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .load_i(load), .load_data_i(load_data),
    .blank_lz_i(blank_lz), .digit_data_o(digit_data), .anode_o(anode),
    .digit_idx_o(digit_idx), .frame_tick_o(frame_tick)
  );

  sevenseg_scan_ctrl #(.NDIGITS(4), .ON_CYCLES(1000), .DEAD_CYCLES(16)) dut_big (
    .clk_i(clk), .reset_i(reset), .enable_i(b_en), .load_i(1'b0), .load_data_i(16'h0000),
    .blank_lz_i(1'b0), .digit_data_o(b_data), .anode_o(b_anode),
    .digit_idx_o(b_idx), .frame_tick_o(b_tick)
  );

  typedef struct {
    logic [3:0] anode;
    logic [3:0] data;
  } slot_t;

  slot_t       sb_q[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          n_overlap = 0;
  logic [15:0] m_shadow, m_pend;
  logic        m_pvalid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!$onehot0(anode) || !$onehot0(b_anode)) n_overlap++;
  end

  task automatic wait_tick(input string tag);
    int w = 0;
    while (frame_tick !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (frame_tick !== 1'b1) check_eq(tag, {31'd0, frame_tick}, 32'd1);
  endtask

  // Runs one 16-cycle frame from its tick cycle; lcN is the cycle index of an optional load.
  task automatic run_frame(input logic lz, input int lc0, input logic [15:0] lv0,
                           input int lc1, input logic [15:0] lv1);
    slot_t cur;
    wait_tick("frame_start");
    blank_lz = lz;
    if (m_pvalid) begin
      m_shadow = m_pend;
      m_pvalid = 1'b0;
    end
    for (int s = 0; s < 4; s++) begin
      slot_t e;
      logic [15:0] upper;
      upper  = m_shadow >> (4 * s);
      e.data = upper[3:0];
      e.anode = (lz && s >= 1 && upper == 16'h0) ? 4'b0000 : 4'(1 << s);
      sb_q.push_back(e);
    end
    cur.anode = 4'h0;
    cur.data  = 4'h0;
    for (int c = 0; c < 16; c++) begin
      int s;
      s = c / 4;
      if (c % 4 == 1) begin
        check_eq("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) cur = sb_q.pop_front();
      end
      check_eq($sformatf("tick c%0d", c), {31'd0, frame_tick}, {31'd0, c == 0});
      check_eq($sformatf("idx c%0d", c), {30'd0, digit_idx}, s);
      if (c % 4 == 0) begin
        check_eq($sformatf("dead_anode c%0d", c), {28'd0, anode}, 32'd0);
      end else begin
        check_eq($sformatf("anode c%0d", c), {28'd0, anode}, {28'd0, cur.anode});
        check_eq($sformatf("data c%0d", c), {28'd0, digit_data}, {28'd0, cur.data});
      end
      if (c == lc0 || c == lc1) begin
        load      = 1'b1;
        load_data = (c == lc0) ? lv0 : lv1;
        m_pend    = load_data;
        m_pvalid  = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  initial begin
    int n, lit, d0, t_d0, t_d1;
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_data = 16'h0; blank_lz = 1'b0; b_en = 1'b0;
    m_shadow = 16'h0; m_pend = 16'h0; m_pvalid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_anode", {28'd0, anode}, 32'd0);
    check_eq("rst_data", {28'd0, digit_data}, 32'd0);
    check_eq("rst_tick", {31'd0, frame_tick}, 32'd0);
    check_eq("rst_idx", {30'd0, digit_idx}, 32'd0);

    // Startup, then a basic value
    reset = 1'b0; enable = 1'b1; b_en = 1'b1;
    @(negedge clk);
    check_eq("t1_first_tick", {31'd0, frame_tick}, 32'd1);
    check_eq("t1_first_dead", {28'd0, anode}, 32'd0);
    run_frame(1'b0, 6, 16'h1234, -1, 16'h0);
    run_frame(1'b0, -1, 16'h0, -1, 16'h0);
    run_frame(1'b0, -1, 16'h0, -1, 16'h0);

    // Leading-zero blanking
    run_frame(1'b1, 2, 16'h0045, -1, 16'h0);
    run_frame(1'b1, 3, 16'h0000, -1, 16'h0);
    run_frame(1'b1, 7, 16'h0405, -1, 16'h0);
    run_frame(1'b1, -1, 16'h0, -1, 16'h0);

    // Double buffering, including a load on the transfer edge
    run_frame(1'b0, 5, 16'h1111, 9, 16'h2222);
    run_frame(1'b0, 15, 16'h5555, -1, 16'h0);
    run_frame(1'b0, 0, 16'h6666, -1, 16'h0);
    run_frame(1'b0, -1, 16'h0, -1, 16'h0);

    // Enable dropped mid-slot, load while dark, restart
    wait_tick("t5_sync");
    repeat (10) @(negedge clk);
    check_eq("t5_digit2_on", {28'd0, anode}, 32'h4);
    check_eq("t5_idx2", {30'd0, digit_idx}, 32'd2);
    enable = 1'b0;
    @(negedge clk);
    check_eq("t5_off_anode", {28'd0, anode}, 32'd0);
    check_eq("t5_off_idx", {30'd0, digit_idx}, 32'd0);
    check_eq("t5_off_tick", {31'd0, frame_tick}, 32'd0);
    load = 1'b1; load_data = 16'h0789; m_pend = 16'h0789; m_pvalid = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_eq("t5_dark", {28'd0, anode}, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check_eq("t5_restart_tick", {31'd0, frame_tick}, 32'd1);
    run_frame(1'b0, -1, 16'h0, -1, 16'h0);

    // Reset during DRIVE discards shadow and pending
    repeat (2) @(negedge clk);
    check_eq("t5_pre_rst_anode", {28'd0, anode}, 32'h1);
    load = 1'b1; load_data = 16'h4321;
    @(negedge clk);
    load = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_anode", {28'd0, anode}, 32'd0);
    check_eq("t5_rst_data", {28'd0, digit_data}, 32'd0);
    check_eq("t5_rst_idx", {30'd0, digit_idx}, 32'd0);
    check_eq("t5_rst_tick", {31'd0, frame_tick}, 32'd0);
    m_shadow = 16'h0; m_pend = 16'h0; m_pvalid = 1'b0;
    sb_q.delete();
    reset = 1'b0;
    @(negedge clk);
    check_eq("t5_post_rst_tick", {31'd0, frame_tick}, 32'd1);
    run_frame(1'b0, -1, 16'h0, -1, 16'h0);

    // Default timing: slot and frame periods
    n = 0;
    while (b_tick !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_tick_seen", {31'd0, b_tick}, 32'd1);
    n = 0; lit = 0; d0 = 0; t_d0 = -1; t_d1 = -1;
    do begin
      if (b_anode != 4'h0) lit++;
      if (b_anode == 4'h1) d0++;
      if (b_anode == 4'h1 && t_d0 < 0) t_d0 = n;
      if (b_anode == 4'h2 && t_d1 < 0) t_d1 = n;
      @(negedge clk);
      n++;
    end while (b_tick !== 1'b1 && n < 5000);
    check_eq("t6_frame_len", n, 32'd4064);
    check_eq("t6_lit_cycles", lit, 32'd4000);
    check_eq("t6_digit0_on", d0, 32'd1000);
    check_eq("t6_digit_period", t_d1 - t_d0, 32'd1016);
    check_eq("anode_overlap", n_overlap, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
